// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, round constants, key-expansion
// FSM states and the AES-128 size constants.
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } kx_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused; rounds 1..10 take entries 1..10.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        logic [7:0] val;
        if (round <= 4'd10) begin
            val = RCON[round];
        end else begin
            val = 8'h00;
        end
        return val;
    endfunction

endpackage

// File: rtl/keyexp_subword.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module keyexp_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_val,
    output logic [31:0] sub_val
);

    // Four independent byte lookups, byte positions preserved.
    always_comb begin
        sub_val = {SBOX[word_val[31:24]], SBOX[word_val[23:16]],
                   SBOX[word_val[15:8]],  SBOX[word_val[7:0]]};
    end

endmodule

// File: rtl/keyexpand.sv
// Iterative AES-128 key expansion, one round key per clock.
// Build option KEYEXP_RESTART_EN: a start while busy restarts with the new key.
module keyexpand
    import aes_pkg::*;
#(
    parameter int Nk = NK,
    parameter int Nr = NR
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iKeyStart,
    input  logic [127:0]  iKey,
    output logic          oKeyBusy,
    output logic [10:0]   oKeyRoundReady,
    output logic [127:0]  oKeyRound00,
    output logic [127:0]  oKeyRound01,
    output logic [127:0]  oKeyRound02,
    output logic [127:0]  oKeyRound03,
    output logic [127:0]  oKeyRound04,
    output logic [127:0]  oKeyRound05,
    output logic [127:0]  oKeyRound06,
    output logic [127:0]  oKeyRound07,
    output logic [127:0]  oKeyRound08,
    output logic [127:0]  oKeyRound09,
    output logic [127:0]  oKeyRound10
);

    kx_state_t      state_r;
    logic [3:0]     round_r;
    logic           busy_r;
    logic [10:0]    ready_r;
    logic [127:0]   keys_r [11];

    logic           accept_s;
    logic [127:0]   prev_s;
    logic [31:0]    rot_s;
    logic [31:0]    sub_s;
    logic [31:0]    t_s;
    logic [127:0]   next_s;

`ifdef KEYEXP_RESTART_EN
    assign accept_s = iKeyStart;
`else
    assign accept_s = iKeyStart && (state_r == IDLE);
`endif

    // Previous round key, selected by the current round counter.
    always_comb begin
        prev_s = 128'h0;
        case (round_r)
            4'd1:    prev_s = keys_r[0];
            4'd2:    prev_s = keys_r[1];
            4'd3:    prev_s = keys_r[2];
            4'd4:    prev_s = keys_r[3];
            4'd5:    prev_s = keys_r[4];
            4'd6:    prev_s = keys_r[5];
            4'd7:    prev_s = keys_r[6];
            4'd8:    prev_s = keys_r[7];
            4'd9:    prev_s = keys_r[8];
            4'd10:   prev_s = keys_r[9];
            default: prev_s = 128'h0;
        endcase
    end

    assign rot_s = {prev_s[103:96], prev_s[127:104]};

    keyexp_subword u_subword (
        .word_val (rot_s),
        .sub_val  (sub_s)
    );

    // Round function: Rcon on the rotated/substituted w3, then the word XOR chain.
    always_comb begin
        t_s          = sub_s ^ {24'h0, rcon_of(round_r)};
        next_s[31:0]   = prev_s[31:0]   ^ t_s;
        next_s[63:32]  = prev_s[63:32]  ^ next_s[31:0];
        next_s[95:64]  = prev_s[95:64]  ^ next_s[63:32];
        next_s[127:96] = prev_s[127:96] ^ next_s[95:64];
    end

    // FSM, round counter, round-key and ready registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= IDLE;
            round_r <= 4'd0;
            busy_r  <= 1'b0;
            ready_r <= 11'h000;
            for (int i = 0; i < 11; i++) begin
                keys_r[i] <= 128'h0;
            end
        end else if (accept_s) begin
            state_r   <= EXPAND;
            round_r   <= 4'd1;
            busy_r    <= 1'b1;
            ready_r   <= 11'h001;
            keys_r[0] <= iKey[32*Nk-1:0];
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                EXPAND: begin
                    for (int i = 1; i < 11; i++) begin
                        if (round_r == 4'(i)) begin
                            keys_r[i]  <= next_s;
                            ready_r[i] <= 1'b1;
                        end
                    end
                    if (round_r == 4'(Nr)) begin
                        state_r <= IDLE;
                        round_r <= 4'd0;
                        busy_r  <= 1'b0;
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    round_r <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oKeyBusy       = busy_r;
    assign oKeyRoundReady = ready_r;
    assign oKeyRound00    = keys_r[0];
    assign oKeyRound01    = keys_r[1];
    assign oKeyRound02    = keys_r[2];
    assign oKeyRound03    = keys_r[3];
    assign oKeyRound04    = keys_r[4];
    assign oKeyRound05    = keys_r[5];
    assign oKeyRound06    = keys_r[6];
    assign oKeyRound07    = keys_r[7];
    assign oKeyRound08    = keys_r[8];
    assign oKeyRound09    = keys_r[9];
    assign oKeyRound10    = keys_r[10];

endmodule

// File: tb/tb_keyexpand.sv
// Bench for keyexpand: byte-level AES key schedule model with a GF(2^8)-derived
// S-box, scoreboard of completed schedules, and per-cycle busy/ready/key checks.
module tb_keyexpand;

`ifdef KEYEXP_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iKeyStart = 1'b0;
    logic [127:0]  iKey = 128'h0;
    logic          oKeyBusy;
    logic [10:0]   oKeyRoundReady;
    logic [127:0]  rk [11];

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]     sb_tab [256];
    logic [1407:0]  sb_q [$];
    logic [1407:0]  cur_sched = '0;
    int             mdl_busy_left = 0;
    int             mdl_cnt = 0;
    bit             mdl_zero = 1'b1;
    bit             mdl_valid = 1'b0;

    keyexpand dut (
        .iClk (iClk), .iRst (iRst), .iKeyStart (iKeyStart), .iKey (iKey),
        .oKeyBusy (oKeyBusy), .oKeyRoundReady (oKeyRoundReady),
        .oKeyRound00 (rk[0]), .oKeyRound01 (rk[1]), .oKeyRound02 (rk[2]),
        .oKeyRound03 (rk[3]), .oKeyRound04 (rk[4]), .oKeyRound05 (rk[5]),
        .oKeyRound06 (rk[6]), .oKeyRound07 (rk[7]), .oKeyRound08 (rk[8]),
        .oKeyRound09 (rk[9]), .oKeyRound10 (rk[10])
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 key expansion over words of bytes; round r lands at [128r +: 128].
    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc = 8'h01;
        logic [1407:0] res = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sb_tab[t[1]] ^ rc;
                t[1] = sb_tab[t[2]];
                t[2] = sb_tab[t[3]];
                t[3] = sb_tab[tmp];
                rc   = xtime(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) res[128*r + 32*c + 8*j +: 8] = w[4*r+c][j];
        return res;
    endfunction

    // Reference model: reacts to the bench's own drives at each rising edge.
    initial begin
        forever begin
            @(posedge iClk);
            if (iRst) begin
                mdl_valid = 1'b1;
                mdl_busy_left = 0;
                mdl_cnt = 0;
                mdl_zero = 1'b1;
                sb_q.delete();
            end else if (iKeyStart && (mdl_busy_left == 0 || RESTART)) begin
                if (mdl_busy_left > 0) void'(sb_q.pop_back());
                cur_sched = expand(iKey);
                sb_q.push_back(cur_sched);
                mdl_busy_left = 10;
                mdl_cnt = 1;
                mdl_zero = 1'b0;
            end else if (mdl_busy_left > 0) begin
                mdl_busy_left--;
                mdl_cnt++;
            end
        end
    end

    // Monitor: per-cycle state checks, and a scoreboard pop on each completed schedule.
    initial begin
        bit prev10 = 1'b0;
        logic [1407:0] exp_s;
        logic [10:0] exp_rdy;
        forever begin
            @(negedge iClk);
            if (mdl_valid) begin
                exp_rdy = 11'h000;
                for (int k = 0; k < mdl_cnt; k++) exp_rdy[k] = 1'b1;
                chk("busy", 128'(oKeyBusy), 128'(mdl_busy_left > 0));
                chk("ready", 128'(oKeyRoundReady), 128'(exp_rdy));
                for (int r = 0; r < 11; r++) begin
                    if (mdl_zero) chk($sformatf("zero_key%0d", r), rk[r], 128'h0);
                    else if (r < mdl_cnt) chk($sformatf("key%0d", r), rk[r], cur_sched[128*r +: 128]);
                end
                if (oKeyRoundReady[10] === 1'b1 && !prev10) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_completion", 128'(1), 128'(0));
                    end else begin
                        exp_s = sb_q.pop_front();
                        for (int r = 0; r < 11; r++)
                            chk($sformatf("sched_key%0d", r), rk[r], exp_s[128*r +: 128]);
                    end
                end
                prev10 = (oKeyRoundReady[10] === 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        iKey = k;
        iKeyStart = 1'b1;
        step();
        iKeyStart = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (oKeyBusy !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        chk("done_timeout", 128'(n < 30), 128'(1));
    endtask

    localparam logic [127:0] KEY_A1    = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] A1_R01    = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] A1_R10    = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
    localparam logic [127:0] ZERO_R01  = 128'h63636362_63636362_63636362_63636362;
    localparam logic [127:0] ZERO_R10  = 128'h8e188f6f_cf51e923_11e2923e_cb5befb4;

    initial begin
        logic [127:0] k1, k2;
        logic [1407:0] fin;
        int gap;
        build_sbox();
        repeat (3) step();
        iRst = 1'b0;
        chk("reset_ready", 128'(oKeyRoundReady), 128'h0);
        chk("reset_busy", 128'(oKeyBusy), 128'h0);
        chk("reset_key10", rk[10], 128'h0);

        // FIPS-197 A.1 key, with exact ready[10] timing
        start_key(KEY_A1);
        repeat (9) step();
        chk("a1_r10_not_yet", 128'(oKeyRoundReady[10]), 128'h0);
        chk("a1_busy_e9", 128'(oKeyBusy), 128'h1);
        step();
        chk("a1_r10_at_e10", 128'(oKeyRoundReady[10]), 128'h1);
        chk("a1_busy_e10", 128'(oKeyBusy), 128'h0);
        chk("a1_round01", rk[1], A1_R01);
        chk("a1_round10", rk[10], A1_R10);

        // All-zero key
        start_key(128'h0);
        wait_done();
        chk("zero_round01", rk[1], ZERO_R01);
        chk("zero_round10", rk[10], ZERO_R10);
        chk("zero_ready", 128'(oKeyRoundReady), 128'h7ff);

        // Reset together with start at start+5
        start_key(KEY_A1);
        repeat (4) step();
        iRst = 1'b1;
        iKeyStart = 1'b1;
        iKey = 128'h1;
        step();
        iRst = 1'b0;
        iKeyStart = 1'b0;
        chk("rst_mid_ready", 128'(oKeyRoundReady), 128'h0);
        chk("rst_mid_busy", 128'(oKeyBusy), 128'h0);
        chk("rst_mid_key00", rk[0], 128'h0);
        repeat (2) step();
        chk("rst_no_expand", 128'(oKeyRoundReady), 128'h0);

        // Second start at start+4
        k1 = 128'h00112233_44556677_8899aabb_ccddeeff;
        k2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        start_key(k1);
        repeat (3) step();
        start_key(k2);
        chk("restart_ready", 128'(oKeyRoundReady), RESTART ? 128'h001 : 128'h01f);
        chk("restart_key00", rk[0], RESTART ? k2 : k1);
        wait_done();
        fin = expand(RESTART ? k2 : k1);
        chk("restart_final10", rk[10], fin[1280 +: 128]);

        // Back-to-back: start on the first idle cycle
        start_key(k2);
        wait_done();
        chk("b2b_full", 128'(oKeyRoundReady), 128'h7ff);
        start_key(k1);
        chk("b2b_ready", 128'(oKeyRoundReady), 128'h001);
        chk("b2b_key00", rk[0], k1);
        wait_done();

        // Randomized keys, gaps, starts-while-busy and occasional resets
        for (int it = 0; it < 24; it++) begin
            start_key({$urandom(), $urandom(), $urandom(), $urandom()});
            gap = $urandom_range(0, 13);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 9) == 0) start_key({$urandom(), $urandom(), $urandom(), $urandom()});
                else step();
            end
            if ($urandom_range(0, 15) == 0) begin
                iRst = 1'b1;
                step();
                iRst = 1'b0;
            end
        end
        wait_done();
        repeat (2) step();
        chk("scoreboard_drained", 128'(sb_q.size()), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
